// File: rtl/topk_serializer.sv
// topk_serializer: captures a sorted K x 16 vector and replays it one element per beat, largest first.
// Define TOPK_SER_OVERLAP_EN to let the final beat of one frame and the load of the next share a cycle.
module topk_serializer #(
  parameter int K       = 8,
  parameter int sortdir = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [K*16-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [15:0]     out_data,
  output logic [$clog2(K)-1:0]   out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  localparam int IW = $clog2(K);
  localparam logic [IW-1:0] LAST_RANK = IW'(K - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rank;
  logic [K*16-1:0] r_vec;
  logic [15:0]     r_frame_cnt;

  logic            w_send;
  logic            w_at_last;
  logic            w_out_fire;
  logic            w_in_fire;
  logic [IW-1:0]   w_lane;

  assign w_send     = (r_state == SEND);
  assign w_at_last  = (r_rank == LAST_RANK);
  assign w_out_fire = w_send && out_ready;

`ifdef TOPK_SER_OVERLAP_EN
  assign in_ready = !w_send || (out_ready && w_at_last);
`else
  assign in_ready = !w_send;
`endif

  assign w_in_fire = in_valid && in_ready;

  // Rank 0 is always the maximum, so ascending input is read from the top lane down.
  assign w_lane = (sortdir != 0) ? r_rank : (LAST_RANK - r_rank);

  assign out_valid = w_send;
  assign busy      = w_send;
  assign out_data  = w_send ? r_vec[{w_lane, 4'b0000} +: 16] : '0;
  assign out_idx   = r_rank;
  assign out_last  = w_send && w_at_last;
  assign frame_cnt = r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rank      <= '0;
      r_vec       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_vec   <= in_data;
            r_rank  <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_out_fire) begin
            if (w_at_last) begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_rank      <= '0;
              r_state     <= IDLE;
`ifdef TOPK_SER_OVERLAP_EN
              if (w_in_fire) begin
                r_vec   <= in_data;
                r_state <= SEND;
              end
`endif
            end else begin
              r_rank <= r_rank + IW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_topk_serializer.sv
// Self-checking bench for topk_serializer: one ascending (sortdir=0) and one descending (sortdir=1)
// instance share the same stimulus; directed scenarios plus a randomized run against a beat-queue model.
module tb_topk_serializer;

  localparam int K = 8;
`ifdef TOPK_SER_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           out_ready;
  logic [K*16-1:0] in_data;

  logic           aInReady, aValid, aLast, aBusy;
  logic [15:0]    aData, aFrames;
  logic [2:0]     aIdx;
  logic           bInReady, bValid, bLast, bBusy;
  logic [15:0]    bData, bFrames;
  logic [2:0]     bIdx;

  int             nVectors = 0;
  int             nMiscompares = 0;
  logic [15:0]    expFrames;

  // One expected beat: what each lane-order instance should show at a given rank
  typedef struct packed {
    logic [15:0] asc;
    logic [15:0] desc;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  beat_t expQ[$];

  int inLanes[2][K] = '{'{-5, -1, 0, 3, 7, 9, 100, 32767},
                        '{50, 40, 30, 20, 10, 0, -10, -32768}};

  topk_serializer #(.K(K), .sortdir(0)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(aInReady), .in_data(in_data),
    .out_valid(aValid), .out_ready(out_ready), .out_data(aData), .out_idx(aIdx),
    .out_last(aLast), .busy(aBusy), .frame_cnt(aFrames)
  );

  topk_serializer #(.K(K), .sortdir(1)) dutB (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(bInReady), .in_data(in_data),
    .out_valid(bValid), .out_ready(out_ready), .out_data(bData), .out_idx(bIdx),
    .out_last(bLast), .busy(bBusy), .frame_cnt(bFrames)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs on the falling edge and let outputs settle before sampling
  task automatic tick(input logic r, input logic iv, input logic [K*16-1:0] d, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  function automatic logic [15:0] lane(input logic [K*16-1:0] v, input int i);
    return v[16*i +: 16];
  endfunction

  function automatic logic [K*16-1:0] randVec();
    logic [K*16-1:0] v;
    for (int i = 0; i < K; i++) v[16*i +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 1'b1, randVec(), 1'b1);
      nVectors++;
      if ({aValid, aInReady, aData, aIdx, aLast, aBusy, aFrames} !== {1'b0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0}) begin
        nMiscompares++;
        $display("[TB] FAIL reset_outputs_A cycle %0d: got v=%b r=%b d=%h i=%0d l=%b b=%b f=%0d, want v=0 r=1 d=0 i=0 l=0 b=0 f=0",
                 c, aValid, aInReady, aData, aIdx, aLast, aBusy, aFrames);
      end
      nVectors++;
      if ({bValid, bInReady, bData, bIdx, bLast, bBusy, bFrames} !== {1'b0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0}) begin
        nMiscompares++;
        $display("[TB] FAIL reset_outputs_B cycle %0d: got v=%b r=%b d=%h f=%0d, want v=0 r=1 d=0 f=0",
                 c, bValid, bInReady, bData, bFrames);
      end
    end
    tick(1'b0, 1'b0, '0, 1'b1);
    expFrames = 16'd0;
    nVectors++;
    if ({aValid, aInReady, bValid} !== 3'b010) begin
      nMiscompares++;
      $display("[TB] FAIL reset_nothing_captured: got aValid=%b aInReady=%b bValid=%b, want 0 1 0", aValid, aInReady, bValid);
    end
  endtask

  // Ascending vector then descending vector through both lane-order instances
  task automatic test_lane_order();
    logic [K*16-1:0] v;
    logic [15:0]     expA, expB;
    logic            expIr;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < K; i++) v[16*i +: 16] = 16'(inLanes[f][i]);
      tick(1'b0, 1'b1, v, 1'b1);
      nVectors++;
      if ({aInReady, aValid} !== 2'b10) begin
        nMiscompares++;
        $display("[TB] FAIL order_idle f=%0d: got in_ready=%b out_valid=%b, want 1 0", f, aInReady, aValid);
      end
      for (int r = 0; r < K; r++) begin
        tick(1'b0, 1'b0, '0, 1'b1);
        expA  = 16'(inLanes[f][K-1-r]);
        expB  = 16'(inLanes[f][r]);
        expIr = OVERLAP && (r == K-1);
        nVectors++;
        if ({aValid, aBusy, aIdx, aLast, aData, aInReady} !== {1'b1, 1'b1, 3'(r), (r == K-1), expA, expIr}) begin
          nMiscompares++;
          $display("[TB] FAIL order_beat_A f=%0d r=%0d: got v=%b i=%0d l=%b d=%0d ir=%b, want v=1 i=%0d l=%b d=%0d ir=%b",
                   f, r, aValid, aIdx, aLast, $signed(aData), aInReady, r, (r == K-1), $signed(expA), expIr);
        end
        nVectors++;
        if ({bValid, bIdx, bLast, bData} !== {1'b1, 3'(r), (r == K-1), expB}) begin
          nMiscompares++;
          $display("[TB] FAIL order_beat_B f=%0d r=%0d: got v=%b i=%0d l=%b d=%0d, want d=%0d",
                   f, r, bValid, bIdx, bLast, $signed(bData), $signed(expB));
        end
      end
      expFrames = expFrames + 16'd1;
      tick(1'b0, 1'b0, '0, 1'b0);
      nVectors++;
      if ({aValid, aFrames, bFrames} !== {1'b0, expFrames, expFrames}) begin
        nMiscompares++;
        $display("[TB] FAIL order_frame_end f=%0d: got v=%b fa=%0d fb=%0d, want v=0 f=%0d", f, aValid, aFrames, bFrames, expFrames);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [K*16-1:0] v;
    v = randVec();
    tick(1'b0, 1'b1, v, 1'b1);
    for (int s = 0; s < K + 4; s++) begin
      int r;
      logic ordy;
      ordy = !(s >= 3 && s < 7);
      r    = (s < 3) ? s : (s < 7 ? 3 : s - 4);
      tick(1'b0, 1'b0, '0, ordy);
      nVectors++;
      if ({aValid, aIdx, aData, bData} !== {1'b1, 3'(r), lane(v, K-1-r), lane(v, r)}) begin
        nMiscompares++;
        $display("[TB] FAIL backpressure step %0d: got v=%b i=%0d da=%h db=%h, want v=1 i=%0d da=%h db=%h",
                 s, aValid, aIdx, aData, bData, r, lane(v, K-1-r), lane(v, r));
      end
    end
    expFrames = expFrames + 16'd1;
    tick(1'b0, 1'b0, '0, 1'b0);
    nVectors++;
    if ({aValid, aFrames} !== {1'b0, expFrames}) begin
      nMiscompares++;
      $display("[TB] FAIL backpressure_frame_end: got v=%b f=%0d, want v=0 f=%0d", aValid, aFrames, expFrames);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [K*16-1:0] v, w;
    tick(1'b1, 1'b0, '0, 1'b0);
    expFrames = 16'd0;
    v = randVec();
    tick(1'b0, 1'b1, v, 1'b1);
    for (int r = 0; r < 5; r++) tick(1'b0, 1'b0, '0, 1'b1);
    tick(1'b1, 1'b0, '0, 1'b1);
    nVectors++;
    if ({aValid, aIdx, aData} !== {1'b1, 3'd5, lane(v, K-1-5)}) begin
      nMiscompares++;
      $display("[TB] FAIL midreset_at_rank5: got v=%b i=%0d d=%h, want v=1 i=5 d=%h", aValid, aIdx, aData, lane(v, K-1-5));
    end
    tick(1'b0, 1'b0, '0, 1'b1);
    nVectors++;
    if ({aValid, aInReady, aIdx, aData, aFrames, bValid} !== {1'b0, 1'b1, 3'd0, 16'h0, expFrames, 1'b0}) begin
      nMiscompares++;
      $display("[TB] FAIL midreset_dropped: got v=%b ir=%b i=%0d d=%h f=%0d, want v=0 ir=1 i=0 d=0 f=%0d",
               aValid, aInReady, aIdx, aData, aFrames, expFrames);
    end
    w = randVec();
    tick(1'b0, 1'b1, w, 1'b1);
    for (int r = 0; r < K; r++) begin
      tick(1'b0, 1'b0, '0, 1'b1);
      nVectors++;
      if ({aValid, aIdx, aLast, aData, bData} !== {1'b1, 3'(r), (r == K-1), lane(w, K-1-r), lane(w, r)}) begin
        nMiscompares++;
        $display("[TB] FAIL midreset_new_frame r=%0d: got v=%b i=%0d l=%b da=%h db=%h, want i=%0d da=%h db=%h",
                 r, aValid, aIdx, aLast, aData, bData, r, lane(w, K-1-r), lane(w, r));
      end
    end
    expFrames = expFrames + 16'd1;
    tick(1'b0, 1'b0, '0, 1'b0);
    nVectors++;
    if (aFrames !== expFrames) begin
      nMiscompares++;
      $display("[TB] FAIL midreset_frame_cnt: got %0d, want %0d", aFrames, expFrames);
    end
  endtask

  // Two frames with in_valid held high; counts cycles from the first handshake to the second out_last
  task automatic test_back_to_back();
    logic [K*16-1:0] vecs[2];
    int accepted, lastsSeen, beatIdx, cycles, frame;
    logic iv;
    vecs[0] = randVec();
    vecs[1] = randVec();
    accepted = 0; lastsSeen = 0; beatIdx = 0; cycles = 0;
    tick(1'b0, 1'b1, vecs[0], 1'b1);
    nVectors++;
    if (aInReady !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL b2b_first_ready: got %b, want 1", aInReady);
    end
    accepted = 1;
    for (int c = 1; c <= 40 && lastsSeen < 2; c++) begin
      iv = (accepted < 2);
      tick(1'b0, iv, vecs[1], 1'b1);
      cycles = c;
      if (aValid) begin
        frame = lastsSeen;
        nVectors++;
        if ({aIdx, aLast, aData, bData} !== {3'(beatIdx), (beatIdx == K-1), lane(vecs[frame], K-1-beatIdx), lane(vecs[frame], beatIdx)}) begin
          nMiscompares++;
          $display("[TB] FAIL b2b_beat frame %0d cycle %0d: got i=%0d l=%b da=%h, want i=%0d da=%h",
                   frame, c, aIdx, aLast, aData, beatIdx, lane(vecs[frame], K-1-beatIdx));
        end
        if (beatIdx == K-1) lastsSeen++;
        beatIdx = (beatIdx + 1) % K;
      end
      if (iv && aInReady) accepted++;
    end
    nVectors++;
    if (lastsSeen != 2 || cycles != (OVERLAP ? 2*K : 2*K + 1)) begin
      nMiscompares++;
      $display("[TB] FAIL b2b_timing: got %0d frames in %0d cycles, want 2 frames in %0d cycles",
               lastsSeen, cycles, (OVERLAP ? 2*K : 2*K + 1));
    end
    expFrames = expFrames + 16'd2;
    tick(1'b0, 1'b0, '0, 1'b0);
    nVectors++;
    if ({aValid, aFrames, bFrames} !== {1'b0, expFrames, expFrames}) begin
      nMiscompares++;
      $display("[TB] FAIL b2b_frame_cnt: got v=%b fa=%0d fb=%0d, want v=0 f=%0d", aValid, aFrames, bFrames, expFrames);
    end
  endtask

  task automatic test_wrap();
    logic [K*16-1:0] v;
    tick(1'b0, 1'b0, '0, 1'b0);
    force dutA.r_frame_cnt = 16'hFFFF;
    force dutB.r_frame_cnt = 16'hFFFF;
    tick(1'b0, 1'b0, '0, 1'b0);
    release dutA.r_frame_cnt;
    release dutB.r_frame_cnt;
    expFrames = 16'hFFFF;
    v = randVec();
    tick(1'b0, 1'b1, v, 1'b1);
    for (int r = 0; r < K; r++) tick(1'b0, 1'b0, '0, 1'b1);
    expFrames = expFrames + 16'd1;
    tick(1'b0, 1'b0, '0, 1'b0);
    nVectors++;
    if ({aValid, aFrames, bFrames} !== {1'b0, expFrames, expFrames}) begin
      nMiscompares++;
      $display("[TB] FAIL wrap_frame_cnt: got v=%b fa=%h fb=%h, want v=0 f=%h", aValid, aFrames, bFrames, expFrames);
    end
  endtask

  // Random valid/ready traffic against a queue of pending beats; the tail drains with ready high
  task automatic test_random();
    logic [K*16-1:0] d;
    logic iv, ordy, expValid, expIr;
    expQ.delete();
    for (int c = 0; c < 420; c++) begin
      iv   = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
      ordy = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      d    = randVec();
      tick(1'b0, iv, d, ordy);
      expValid = (expQ.size() > 0);
      expIr    = (expQ.size() == 0) || (OVERLAP && expQ.size() == 1 && ordy);
      nVectors++;
      if ({aValid, aInReady, aFrames, bValid, bInReady, bFrames} !== {expValid, expIr, expFrames, expValid, expIr, expFrames}) begin
        nMiscompares++;
        $display("[TB] FAIL random_ctrl cycle %0d: got v=%b ir=%b f=%0d, want v=%b ir=%b f=%0d",
                 c, aValid, aInReady, aFrames, expValid, expIr, expFrames);
      end
      if (expValid) begin
        nVectors++;
        if ({aIdx, aLast, aData, bIdx, bData} !== {expQ[0].idx, expQ[0].last, expQ[0].asc, expQ[0].idx, expQ[0].desc}) begin
          nMiscompares++;
          $display("[TB] FAIL random_beat cycle %0d: got i=%0d l=%b da=%h db=%h, want i=%0d l=%b da=%h db=%h",
                   c, aIdx, aLast, aData, bData, expQ[0].idx, expQ[0].last, expQ[0].asc, expQ[0].desc);
        end
      end
      if (expValid && ordy) begin
        if (expQ[0].last) expFrames = expFrames + 16'd1;
        void'(expQ.pop_front());
      end
      if (iv && expIr) begin
        for (int r = 0; r < K; r++) expQ.push_back('{lane(d, K-1-r), lane(d, r), 3'(r), (r == K-1)});
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    expFrames = 16'd0;
    test_reset();
    test_lane_order();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
